// File: rtl/sb_spram_pkg.sv
// Shared definitions for the single-port 16-bit nibble-masked SPRAM.
// Latency: n/a (types, widths and a mode-decode helper only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W, DATA_W, NIBBLES : interface widths
//   mode_e                  : power mode, listed in priority order
//   decode_mode()           : maps raw power pins onto mode_e
package sb_spram_pkg;

   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 16;
   localparam int NIBBLES = 4;

   typedef enum logic [1:0] {
      MODE_ACTIVE  = 2'd0,
      MODE_STANDBY = 2'd1,
      MODE_SLEEP   = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   // POWEROFF is active-low; OFF dominates SLEEP, which dominates STANDBY.
   function automatic mode_e decode_mode(input logic poweroff,
                                         input logic sleep,
                                         input logic standby);
      mode_e m;
      if (!poweroff)    m = MODE_OFF;
      else if (sleep)   m = MODE_SLEEP;
      else if (standby) m = MODE_STANDBY;
      else              m = MODE_ACTIVE;
      return m;
   endfunction

endpackage

// File: rtl/spram_array.sv
// Nibble-masked word storage with a per-word valid bit.
// Latency: combinational read of the addressed word; writes and invalidation take effect at the clock edge.
// Backpressure: none; every enabled write is accepted in the cycle it is presented.
//
// Ports:
//   clk      : clock, all updates on its rising edge
//   wr_en    : write the masked word this cycle (caller guarantees mask is non-zero)
//   clr_all  : clear every valid bit at this edge (power-off invalidation)
//   addr     : word address; addresses >= DEPTH are ignored for writes and read as zero
//   wdata    : write data
//   mask     : per-nibble write enable, bit i covers wdata[4i+3:4i]
//   rdata    : current contents of addr (zero if invalid or out of range)
import sb_spram_pkg::*;

module spram_array #(
   parameter int DEPTH = 16384
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic                clr_all,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [NIBBLES-1:0]  mask,
   output logic [DATA_W-1:0]   rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   // Power-on value: every word starts invalid so unwritten words read zero.
   // The data array itself needs no initial value because valid gates it.
   logic [DEPTH-1:0]  valid_q = '0;

   logic [IDX_W-1:0]  idx;
   logic              in_range;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] merged;

   always_comb begin
      idx      = addr[IDX_W-1:0];
      in_range = (32'(addr) < DEPTH);
      cur      = '0;
      if (in_range && valid_q[idx]) begin
         cur = mem[idx];
      end
      // An invalid word contributes zeros, so a partial write to it
      // zero-fills the nibbles that are not being written.
      merged = cur;
      for (int n = 0; n < NIBBLES; n++) begin
         if (mask[n]) begin
            merged[4*n +: 4] = wdata[4*n +: 4];
         end
      end
      rdata = cur;
   end

   always_ff @(posedge clk) begin
      if (clr_all) begin
         valid_q <= '0;
      end else if (wr_en && in_range) begin
         valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && in_range) begin
         mem[idx] <= merged;
      end
   end

endmodule

// File: rtl/sb_spram_256ka.sv
// Single-port 16K x 16 SPRAM with nibble write mask and optional power modes.
// Latency: read data appears on DATAOUT one clock after the read edge; writes land at the edge.
// Backpressure: none; accesses are blocked only by RESET or a non-active power mode.
//
// Ports:
//   CLOCK      : sole clock, rising edge
//   RESET      : synchronous active-high; zeroes DATAOUT, blocks access, keeps memory
//   ADDRESS    : word address
//   DATAIN     : write data
//   MASKWREN   : per-nibble write enable
//   WREN       : 1 = write cycle, 0 = read cycle
//   CHIPSELECT : access enable
//   STANDBY    : hold, no access, DATAOUT holds
//   SLEEP      : no access, DATAOUT cleared
//   POWEROFF   : active-low power; low clears DATAOUT and invalidates every word
//   DATAOUT    : registered read data
//
// Build option: define SPRAM_POWER_MODES_EN to honour STANDBY, SLEEP and
// POWEROFF. Without it those pins are ignored and the RAM is always active.
import sb_spram_pkg::*;

module sb_spram_256ka #(
   parameter int DEPTH = 16384
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic [ADDR_W-1:0]   ADDRESS,
   input  logic [DATA_W-1:0]   DATAIN,
   input  logic [NIBBLES-1:0]  MASKWREN,
   input  logic                WREN,
   input  logic                CHIPSELECT,
   input  logic                STANDBY,
   input  logic                SLEEP,
   input  logic                POWEROFF,
   output logic [DATA_W-1:0]   DATAOUT
);

   mode_e             mode;
   logic              access;
   logic              wr_en;
   logic              rd_en;
   logic              clr_all;
   logic              force_zero;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] dout_d;

   // DATAOUT powers up at zero.
   logic [DATA_W-1:0] dout_q = '0;

`ifdef SPRAM_POWER_MODES_EN
   assign mode = decode_mode(POWEROFF, SLEEP, STANDBY);
`else
   logic unused_pwr;
   assign unused_pwr = ^{STANDBY, SLEEP, POWEROFF};
   assign mode       = MODE_ACTIVE;
`endif

   always_comb begin
      access     = !RESET && (mode == MODE_ACTIVE) && CHIPSELECT;
      // An all-zero mask is a no-op write; it must not mark the word valid.
      wr_en      = access && WREN && (|MASKWREN);
      rd_en      = access && !WREN;
      // Invalidation is a power event, not an access, but RESET still
      // leaves valid bits untouched.
      clr_all    = !RESET && (mode == MODE_OFF);
      force_zero = (mode == MODE_SLEEP) || (mode == MODE_OFF);
      dout_d     = dout_q;
      if (force_zero) begin
         dout_d = '0;
      end else if (rd_en) begin
         dout_d = rdata;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign DATAOUT = dout_q;

   spram_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (CLOCK),
      .wr_en   (wr_en),
      .clr_all (clr_all),
      .addr    (ADDRESS),
      .wdata   (DATAIN),
      .mask    (MASKWREN),
      .rdata   (rdata)
   );

endmodule

// File: tb/tb_sb_spram_256ka.sv
// Directed bench for sb_spram_256ka (DEPTH reduced to 1024 to reach the out-of-range path).
// Latency checked: DATAOUT sampled 1 ns after the edge that performs each access.
// Backpressure: n/a.
module tb_sb_spram_256ka;

   localparam int DEPTH = 1024;

`ifdef SPRAM_POWER_MODES_EN
   localparam bit PM = 1'b1;
`else
   localparam bit PM = 1'b0;
`endif

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [13:0] ADDRESS;
   logic [15:0] DATAIN;
   logic [3:0]  MASKWREN;
   logic        WREN;
   logic        CHIPSELECT;
   logic        STANDBY;
   logic        SLEEP;
   logic        POWEROFF;
   logic [15:0] DATAOUT;

   int n_checks = 0;
   int n_fail   = 0;

   sb_spram_256ka #(
      .DEPTH (DEPTH)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .ADDRESS    (ADDRESS),
      .DATAIN     (DATAIN),
      .MASKWREN   (MASKWREN),
      .WREN       (WREN),
      .CHIPSELECT (CHIPSELECT),
      .STANDBY    (STANDBY),
      .SLEEP      (SLEEP),
      .POWEROFF   (POWEROFF),
      .DATAOUT    (DATAOUT)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic idle();
      CHIPSELECT = 1'b0;
      WREN       = 1'b0;
      MASKWREN   = 4'h0;
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
      ADDRESS    = a;
      DATAIN     = d;
      MASKWREN   = m;
      WREN       = 1'b1;
      CHIPSELECT = 1'b1;
      tick();
      idle();
   endtask

   task automatic rd(input logic [13:0] a);
      ADDRESS    = a;
      WREN       = 1'b0;
      CHIPSELECT = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      RESET    = 1'b1;
      ADDRESS  = '0;
      DATAIN   = '0;
      STANDBY  = 1'b0;
      SLEEP    = 1'b0;
      POWEROFF = 1'b1;
      idle();
      tick();
      check("reset_dout", DATAOUT, 16'h0000);
      RESET = 1'b0;

      // Unwritten word reads zero after power-on.
      rd(14'h0005);            check("poweron_unwritten", DATAOUT, 16'h0000);

      // Full write, DATAOUT holds during the write, then 1-cycle read.
      wr(14'h0005, 16'hBEEF, 4'hF);
      check("write_holds_dout", DATAOUT, 16'h0000);
      rd(14'h0005);            check("full_write_read", DATAOUT, 16'hBEEF);

      // Nibbles 0 and 2 replaced: B E E F + 1 2 3 4 -> B 2 E 4.
      wr(14'h0005, 16'h1234, 4'b0101);
      check("partial_write_holds", DATAOUT, 16'hBEEF);
      rd(14'h0005);            check("partial_mask", DATAOUT, 16'hB2E4);
      wr(14'h0005, 16'hBEEF, 4'hF);

      // Back-to-back write then read of the same address.
      wr(14'h0020, 16'hCAFE, 4'hF);
      rd(14'h0020);            check("wr_then_rd", DATAOUT, 16'hCAFE);

      // All-zero mask changes nothing.
      wr(14'h0005, 16'hFFFF, 4'h0);
      check("mask0_holds_dout", DATAOUT, 16'hCAFE);
      rd(14'h0005);            check("mask0_no_change", DATAOUT, 16'hBEEF);

      // Deselected write cycle: no write, DATAOUT holds.
      rd(14'h0020);
      ADDRESS = 14'h0005; DATAIN = 16'hFFFF; MASKWREN = 4'hF; WREN = 1'b1; CHIPSELECT = 1'b0;
      tick();
      idle();
      check("cs0_dout_holds", DATAOUT, 16'hCAFE);
      rd(14'h0005);            check("cs0_no_write", DATAOUT, 16'hBEEF);

      // Partial write to an invalid word zero-fills the other nibbles.
      wr(14'h0030, 16'h1234, 4'b0011);
      rd(14'h0030);            check("invalid_zero_fill", DATAOUT, 16'h0034);

      // Out of range: write dropped, read zero, no alias onto word 0.
      wr(14'h0400, 16'h7777, 4'hF);
      rd(14'h0005);
      rd(14'h0400);            check("oor_read_zero", DATAOUT, 16'h0000);
      rd(14'h0000);            check("oor_no_alias", DATAOUT, 16'h0000);

      // RESET with a write presented: DATAOUT zeroed, write blocked.
      rd(14'h0005);            check("pre_reset_read", DATAOUT, 16'hBEEF);
      RESET = 1'b1;
      ADDRESS = 14'h0005; DATAIN = 16'h0000; MASKWREN = 4'hF; WREN = 1'b1; CHIPSELECT = 1'b1;
      tick();
      idle();
      RESET = 1'b0;
      check("reset_zero_dout", DATAOUT, 16'h0000);
      rd(14'h0005);            check("reset_keeps_mem", DATAOUT, 16'hBEEF);

      // STANDBY with a write presented.
      rd(14'h0020);
      STANDBY = 1'b1;
      ADDRESS = 14'h0020; DATAIN = 16'h0000; MASKWREN = 4'hF; WREN = 1'b1; CHIPSELECT = 1'b1;
      tick();
      idle();
      STANDBY = 1'b0;
      check("standby_dout_holds", DATAOUT, 16'hCAFE);
      rd(14'h0020);            check("standby_write", DATAOUT, PM ? 16'hCAFE : 16'h0000);

      // SLEEP for three cycles, then read back retained data.
      wr(14'h0010, 16'hA5A5, 4'hF);
      rd(14'h0005);
      SLEEP = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sleep_dout", DATAOUT, PM ? 16'h0000 : 16'hBEEF);
      end
      SLEEP = 1'b0;
      rd(14'h0010);            check("sleep_retain", DATAOUT, 16'hA5A5);

      // One cycle of power-off invalidates everything.
      POWEROFF = 1'b0;
      tick();
      check("off_dout", DATAOUT, PM ? 16'h0000 : 16'hA5A5);
      POWEROFF = 1'b1;
      rd(14'h0010);            check("off_invalidate_10", DATAOUT, PM ? 16'h0000 : 16'hA5A5);
      rd(14'h0005);            check("off_invalidate_05", DATAOUT, PM ? 16'h0000 : 16'hBEEF);
      wr(14'h0010, 16'h00C0, 4'b0010);
      rd(14'h0010);            check("off_zero_fill", DATAOUT, PM ? 16'h00C0 : 16'hA5C5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
